// File: rtl/fpu_issue_ctrl.sv
// Issue sequencer between the integer core and the FP coprocessor datapath.
// Optional memory-ack timeout is enabled by defining FPU_CTRL_TIMEOUT_EN.
module fpu_issue_ctrl #(
    parameter int LAT_ADDSUB     = 2,
    parameter int LAT_MUL        = 3,
    parameter int LAT_DIV        = 8,
    parameter int LAT_MISC       = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [5:0] instr_opcode,
    input  logic [4:0] instr_rs,
    input  logic [4:0] instr_rt,
    input  logic [4:0] instr_rd,
    output logic [5:0] cp_opcode,
    output logic [4:0] cp_addr_in1,
    output logic [4:0] cp_addr_in2,
    output logic [4:0] cp_addr_dest,
    output logic       cp_go,
    output logic       cp_write_data_enable,
    output logic       cp_store_sel,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       retire,
    output logic       illegal_op,
    output logic       busy,
    output logic       mem_timeout,
    output logic       err_sticky
);

    localparam int MAX_AM  = (LAT_ADDSUB > LAT_MUL) ? LAT_ADDSUB : LAT_MUL;
    localparam int MAX_DM  = (LAT_DIV > LAT_MISC) ? LAT_DIV : LAT_MISC;
    localparam int MAX_LAT = (MAX_AM > MAX_DM) ? MAX_AM : MAX_DM;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [5:0] OP_LW = 6'b110111;
    localparam logic [5:0] OP_SW = 6'b111000;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_ILL} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_q, go_d;
    logic             is_sw_q, is_sw_d;
    logic [5:0]       op_q, op_d;
    logic [4:0]       rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic             tmo_hit;
    logic             tmo_fire;

    // Counter preload is LAT-1 so retire lands exactly LAT cycles after accept.
    function automatic logic [CNT_W-1:0] lat_m1(input logic [5:0] op);
        case (op)
            6'b110000, 6'b110001: lat_m1 = CNT_W'(LAT_ADDSUB - 1);
            6'b110010:            lat_m1 = CNT_W'(LAT_MUL - 1);
            6'b110011, 6'b110101: lat_m1 = CNT_W'(LAT_DIV - 1);
            6'b110100, 6'b110110: lat_m1 = CNT_W'(LAT_MISC - 1);
            default:              lat_m1 = '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            go_q    <= 1'b0;
            is_sw_q <= 1'b0;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
            is_sw_q <= is_sw_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        go_d                 = 1'b0;
        is_sw_d              = is_sw_q;
        op_d                 = op_q;
        rs_d                 = rs_q;
        rt_d                 = rt_q;
        rd_d                 = rd_q;
        retire               = 1'b0;
        illegal_op           = 1'b0;
        mem_req              = 1'b0;
        mem_we               = 1'b0;
        cp_store_sel         = 1'b0;
        cp_write_data_enable = 1'b0;
        tmo_fire             = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d = instr_opcode;
                    rs_d = instr_rs;
                    rt_d = instr_rt;
                    rd_d = instr_rd;
                    if (instr_opcode >= 6'b110000 && instr_opcode <= 6'b110110) begin
                        state_d = S_EXEC;
                        cnt_d   = lat_m1(instr_opcode);
                        go_d    = 1'b1;
                    end else if (instr_opcode == OP_LW || instr_opcode == OP_SW) begin
                        state_d = S_MEM;
                        is_sw_d = (instr_opcode == OP_SW);
                    end else begin
                        state_d = S_ILL;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    retire  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_we       = is_sw_q;
                cp_store_sel = is_sw_q;
                // An ack in the limit cycle takes priority over the timeout.
                if (mem_ack) begin
                    retire               = 1'b1;
                    cp_write_data_enable = ~is_sw_q;
                    state_d              = S_IDLE;
                end else if (tmo_hit) begin
                    tmo_fire = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_ILL: begin
                illegal_op = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FPU_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == S_MEM) ? tmo_q + 1'b1 : '0;
            if (tmo_fire) err_q <= 1'b1;
        end
    end

    assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign mem_timeout = tmo_fire;
    assign err_sticky  = err_q;
`else
    logic unused_tmo;
    assign unused_tmo  = ^TIMEOUT_CYCLES ^ tmo_fire;
    assign tmo_hit     = 1'b0;
    assign mem_timeout = 1'b0;
    assign err_sticky  = 1'b0;
`endif

    assign instr_ready  = (state_q == S_IDLE);
    assign busy         = ~instr_ready;
    assign cp_go        = go_q;
    assign cp_opcode    = op_q;
    assign cp_addr_in1  = rs_q;
    assign cp_addr_in2  = rt_q;
    assign cp_addr_dest = rd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; timeout cases run when FPU_CTRL_TIMEOUT_EN is defined.
module tb_fpu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [5:0] instr_opcode;
    logic [4:0] instr_rs, instr_rt, instr_rd;
    logic [5:0] cp_opcode;
    logic [4:0] cp_addr_in1, cp_addr_in2, cp_addr_dest;
    logic       cp_go, cp_write_data_enable, cp_store_sel;
    logic       mem_req, mem_we, mem_ack;
    logic       retire, illegal_op, busy, mem_timeout, err_sticky;
    logic [30:0] outs;

    int checks   = 0;
    int failures = 0;

    fpu_issue_ctrl #(
        .LAT_ADDSUB(2), .LAT_MUL(3), .LAT_DIV(8), .LAT_MISC(1), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_opcode(instr_opcode), .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd),
        .cp_opcode(cp_opcode), .cp_addr_in1(cp_addr_in1), .cp_addr_in2(cp_addr_in2),
        .cp_addr_dest(cp_addr_dest), .cp_go(cp_go), .cp_write_data_enable(cp_write_data_enable),
        .cp_store_sel(cp_store_sel), .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
        .retire(retire), .illegal_op(illegal_op), .busy(busy),
        .mem_timeout(mem_timeout), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    assign outs = {cp_opcode, cp_addr_in1, cp_addr_in2, cp_addr_dest, cp_go,
                   cp_write_data_enable, cp_store_sel, mem_req, mem_we, retire,
                   illegal_op, busy, mem_timeout, err_sticky};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Offer an instruction while idle; returns in the first cycle after the accept edge.
    task automatic accept(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_rs     = rs;
        instr_rt     = rt;
        instr_rd     = rd;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        instr_valid  = 1'b0;
        instr_opcode = '0;
        instr_rs     = '0;
        instr_rt     = '0;
        instr_rd     = '0;
        mem_ack      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", instr_ready, 1);
            check("rst_outs", outs, 0);
        end
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", instr_ready, 1);
        check("post_rst_outs", outs, 0);

        // mul, LAT=3
        accept(6'b110010, 5'd1, 5'd2, 5'd3);
        check("mul_go_t1", cp_go, 1);
        check("mul_ready_t1", instr_ready, 0);
        check("mul_busy_t1", busy, 1);
        check("mul_retire_t1", retire, 0);
        check("mul_addr_t1", {cp_addr_in1, cp_addr_in2, cp_addr_dest}, {5'd1, 5'd2, 5'd3});
        tick();
        check("mul_go_t2", cp_go, 0);
        check("mul_retire_t2", retire, 0);
        tick();
        check("mul_retire_t3", retire, 1);
        check("mul_go_t3", cp_go, 0);
        check("mul_addr_t3", {cp_opcode, cp_addr_in1, cp_addr_in2, cp_addr_dest},
              {6'b110010, 5'd1, 5'd2, 5'd3});
        tick();
        check("mul_ready_t4", instr_ready, 1);
        check("mul_retire_t4", retire, 0);

        // Stray ack while idle must do nothing
        mem_ack = 1'b1;
        tick();
        check("stray_ack_retire", retire, 0);
        check("stray_ack_wde", cp_write_data_enable, 0);
        mem_ack = 1'b0;

        // lw with ack 4 cycles after mem_req rises
        accept(6'b110111, 5'd5, 5'd0, 5'd7);
        check("lw_req_t1", mem_req, 1);
        check("lw_we_t1", mem_we, 0);
        check("lw_wde_t1", cp_write_data_enable, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("lw_req_wait", mem_req, 1);
            check("lw_retire_wait", retire, 0);
        end
        tick();
        mem_ack = 1'b1;
        #1;
        check("lw_wde_ack", cp_write_data_enable, 1);
        check("lw_retire_ack", retire, 1);
        check("lw_addr_in1", cp_addr_in1, 5);
        check("lw_we_ack", mem_we, 0);
        check("lw_sel_ack", cp_store_sel, 0);
        tick();
        mem_ack = 1'b0;
        check("lw_ready_after", instr_ready, 1);
        check("lw_req_after", mem_req, 0);

        // sw then cmp with valid held high
        instr_valid  = 1'b1;
        instr_opcode = 6'b111000;
        instr_rs     = 5'd4;
        instr_rt     = 5'd0;
        instr_rd     = 5'd0;
        tick();
        instr_opcode = 6'b110100;
        instr_rd     = 5'd9;
        check("sw_req_t1", mem_req, 1);
        check("sw_we_t1", mem_we, 1);
        check("sw_sel_t1", cp_store_sel, 1);
        tick();
        check("sw_sel_t2", cp_store_sel, 1);
        check("sw_op_held", cp_opcode, 6'b111000);
        check("sw_ready_t2", instr_ready, 0);
        tick();
        mem_ack = 1'b1;
        #1;
        check("sw_retire_ack", retire, 1);
        check("sw_sel_ack", cp_store_sel, 1);
        check("sw_wde_ack", cp_write_data_enable, 0);
        tick();
        mem_ack = 1'b0;
        check("b2b_ready", instr_ready, 1);
        tick();
        instr_valid = 1'b0;
        check("cmp_op", cp_opcode, 6'b110100);
        check("cmp_go", cp_go, 1);
        check("cmp_retire", retire, 1);
        check("cmp_sel", cp_store_sel, 0);
        check("cmp_dest", cp_addr_dest, 9);
        tick();
        check("cmp_ready_after", instr_ready, 1);
        check("cmp_retire_after", retire, 0);

        // illegal opcode
        accept(6'b000001, 5'd0, 5'd0, 5'd0);
        check("ill_pulse", illegal_op, 1);
        check("ill_retire", retire, 0);
        check("ill_ready_t1", instr_ready, 0);
        tick();
        check("ill_pulse_off", illegal_op, 0);
        check("ill_ready_t2", instr_ready, 1);

        // reset mid div aborts
        accept(6'b110011, 5'd6, 5'd7, 5'd8);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ready", instr_ready, 1);
        check("abort_outs", outs, 0);

`ifdef FPU_CTRL_TIMEOUT_EN
        // sw never acked
        accept(6'b111000, 5'd2, 5'd0, 5'd0);
        for (int i = 1; i < 16; i++) begin
            check("tmo_quiet", mem_timeout, 0);
            tick();
        end
        check("tmo_pulse", mem_timeout, 1);
        check("tmo_retire", retire, 0);
        tick();
        check("tmo_sticky", err_sticky, 1);
        check("tmo_req_drop", mem_req, 0);
        check("tmo_ready", instr_ready, 1);
        check("tmo_pulse_off", mem_timeout, 0);

        // sw acked in its 16th cycle retires normally
        accept(6'b111000, 5'd3, 5'd0, 5'd0);
        for (int i = 1; i < 16; i++) tick();
        mem_ack = 1'b1;
        #1;
        check("tmo_lim_retire", retire, 1);
        check("tmo_lim_pulse", mem_timeout, 0);
        tick();
        mem_ack = 1'b0;
        check("tmo_lim_ready", instr_ready, 1);

        // reset mid-wait clears sticky error
        accept(6'b111000, 5'd3, 5'd0, 5'd0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("tmo_rst_sticky", err_sticky, 0);
        check("tmo_rst_req", mem_req, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
